muldiv_seq: RTL and testbench
=============================

MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width.
REQ-002 Parameter CNT_W, default 6: iteration counter width; SHALL hold WIDTH.
REQ-003 clk  input  1  the single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request pulse; sampled only in IDLE.
REQ-006 alu_op  input  3  operation code from ALU control: 3'b111 MULT, 3'b101 DIV, others ignored.
REQ-007 op_a  input  WIDTH  multiplicand / dividend.
REQ-008 op_b  input  WIDTH  multiplier / divisor.
REQ-009 hi  output  WIDTH  MULT upper product / DIV remainder.
REQ-010 lo  output  WIDTH  MULT lower product / DIV quotient.
REQ-011 busy  output  1  high from accept edge until the cycle done is high, inclusive; drives the pipeline stall.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 div_zero  output  1  sticky flag; set by DIV with op_b==0.

Function
REQ-014 FSM states SHALL be IDLE, MUL, DIV, FIX, DONE.
REQ-015 IDLE with start=1 and alu_op=111 SHALL latch operands, clear the accumulator and counter, and go to MUL.
REQ-016 IDLE with start=1 and alu_op=101 and op_b!=0 SHALL latch operands and go to DIV.
REQ-017 IDLE with start=1, alu_op=101 and op_b==0 SHALL go to DONE directly, set div_zero, hi=op_a, lo=all ones.
REQ-018 start with any other alu_op, or start outside IDLE, SHALL be ignored with no state change.
REQ-019 MUL SHALL perform one shift-add step per cycle, LSB of multiplier first, 2*WIDTH-bit accumulator.
REQ-020 DIV SHALL perform one restoring shift-subtract step per cycle, quotient MSB first.
REQ-021 After exactly WIDTH iterations MUL/DIV SHALL go to FIX (signed build) or DONE (unsigned build).
REQ-022 hi/lo SHALL update only on entry to DONE and hold until the next entry to DONE.
REQ-023 DONE SHALL assert done for one cycle and return to IDLE; a start in DONE is ignored.
REQ-024 Latency: done high in cycle WIDTH+1 after accept edge (unsigned), WIDTH+2 (signed), 1 for divide-by-zero.
REQ-025 div_zero SHALL clear on the next accepted start with a nonzero divisor or a MULT.
REQ-026 Operand inputs SHALL be don't-care after the accept edge.

Reset
REQ-027 reset SHALL force IDLE immediately, aborting any operation in progress.
REQ-028 Reset values: hi=0, lo=0, busy=0, done=0, div_zero=0, counter=0.
REQ-029 The first start after reset deassertion SHALL be accepted normally.

Configuration
REQ-030 Macro MULDIV_SIGNED_EN defined: operands two's-complement; magnitudes iterate; FIX negates product if signs differ, negates quotient if signs differ, remainder takes dividend sign.
REQ-031 Macro undefined: operands unsigned, no FIX state, FIX encoding unreachable.

Structure
REQ-032 Shared package SHALL hold the ALU op encodings (AND 000, OR 001, ADD 010, SUB 011, SLT 100, DIV 101, NOP 110, MULT 111) and the FSM state typedef.
REQ-033 One sub-module, muldiv_step, SHALL implement a single combinational shift-add / shift-subtract iteration, selected by a mode bit.
REQ-034 The top SHALL hold FSM, counter, operand and result registers.

Verification
REQ-035 MULT 7 x 6 (unsigned): done in cycle 33, hi=0, lo=42, busy high cycles 1-33.
REQ-036 DIV 100 / 7: lo=14, hi=2; signed build -100 / 7: lo=-14, hi=-2, done in cycle 34.
REQ-037 DIV 5 / 0: done in cycle 1, div_zero=1, hi=5, lo=32'hFFFFFFFF; next MULT clears div_zero.
REQ-038 MULT 32'hFFFFFFFF x 32'hFFFFFFFF unsigned: hi=32'hFFFFFFFE, lo=1.
REQ-039 Second start during MUL at cycle 10: ignored, first result unchanged, no extra done.
REQ-040 reset asserted at cycle 15 of DIV: busy=0 same cycle, hi/lo=0, next MULT 3 x 3 gives lo=9.

Source files
------------

// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the sequential multiply/divide unit: ALU op
// encodings, FSM state type and iteration-mode type.
package muldiv_seq_pkg;

  localparam int unsigned ALU_OP_W = 3;

  localparam logic [ALU_OP_W-1:0] ALU_AND  = 3'b000;
  localparam logic [ALU_OP_W-1:0] ALU_OR   = 3'b001;
  localparam logic [ALU_OP_W-1:0] ALU_ADD  = 3'b010;
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = 3'b011;
  localparam logic [ALU_OP_W-1:0] ALU_SLT  = 3'b100;
  localparam logic [ALU_OP_W-1:0] ALU_DIV  = 3'b101;
  localparam logic [ALU_OP_W-1:0] ALU_NOP  = 3'b110;
  localparam logic [ALU_OP_W-1:0] ALU_MULT = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  typedef enum logic {
    STEP_MUL = 1'b0,
    STEP_DIV = 1'b1
  } step_mode_t;

endpackage

// File: rtl/muldiv_seq_if.sv
// Request/result bundle between the pipeline (master) and muldiv_seq (slave).
interface muldiv_seq_if #(
  parameter int unsigned WIDTH = 32
);
  import muldiv_seq_pkg::*;

  logic                start;
  logic [ALU_OP_W-1:0] alu_op;
  logic [WIDTH-1:0]    op_a;
  logic [WIDTH-1:0]    op_b;
  logic [WIDTH-1:0]    hi;
  logic [WIDTH-1:0]    lo;
  logic                busy;
  logic                done;
  logic                div_zero;

  modport master (
    output start, alu_op, op_a, op_b,
    input  hi, lo, busy, done, div_zero
  );

  modport slave (
    input  start, alu_op, op_a, op_b,
    output hi, lo, busy, done, div_zero
  );

endinterface

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add (multiply, LSB first) or restoring
// shift-subtract (divide, quotient MSB first) on a 2*WIDTH accumulator.
module muldiv_step
  import muldiv_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  step_mode_t         mode,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH-1:0] acc_nxt_c
);

  logic [WIDTH:0] addend;
  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;

  // Multiply keeps the running product in the upper half and the unconsumed
  // multiplier bits in the lower half; divide keeps {remainder, dividend/quotient}.
  always_comb begin
    addend    = acc[0] ? {1'b0, operand} : '0;
    sum       = {1'b0, acc[2*WIDTH-1:WIDTH]} + addend;
    rem_sh    = acc[2*WIDTH-1:WIDTH-1];
    diff      = rem_sh - {1'b0, operand};
    acc_nxt_c = acc;
    if (mode == STEP_MUL) begin
      acc_nxt_c = {sum, acc[WIDTH-1:1]};
    end else if (!diff[WIDTH]) begin
      acc_nxt_c = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_nxt_c = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Sequential multiply/divide unit, one iteration per cycle.
// Define MULDIV_SIGNED_EN for two's-complement operands (adds a FIX cycle).
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input logic        clk,
  input logic        reset,
  muldiv_seq_if.slave bus
);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;
  logic               busy_r;
  logic               done_r;
  logic               div_zero_r;

  logic [WIDTH-1:0]   a_in_c;
  logic [WIDTH-1:0]   b_in_c;
  logic [2*WIDTH-1:0] step_nxt_c;
  step_mode_t         mode_c;
  logic               last_c;

`ifdef MULDIV_SIGNED_EN
  logic               neg_a;
  logic               neg_b;
  logic               is_div;
  logic [2*WIDTH-1:0] prod_fix_c;
  logic [WIDTH-1:0]   quo_fix_c;
  logic [WIDTH-1:0]   rem_fix_c;

  // Iterate on magnitudes; the most negative value maps onto itself as unsigned.
  always_comb begin
    a_in_c = bus.op_a[WIDTH-1] ? (~bus.op_a + 1'b1) : bus.op_a;
    b_in_c = bus.op_b[WIDTH-1] ? (~bus.op_b + 1'b1) : bus.op_b;
  end

  always_comb begin
    prod_fix_c = (neg_a ^ neg_b) ? (~acc + 1'b1) : acc;
    quo_fix_c  = (neg_a ^ neg_b) ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
    rem_fix_c  = neg_a ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
  end
`else
  always_comb begin
    a_in_c = bus.op_a;
    b_in_c = bus.op_b;
  end
`endif

  assign mode_c = (state == ST_DIV) ? STEP_DIV : STEP_MUL;
  assign last_c = (cnt == CNT_W'(WIDTH - 1));

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .mode      (mode_c),
    .acc       (acc),
    .operand   (opnd),
    .acc_nxt_c (step_nxt_c)
  );

  // Control FSM with counter, operand and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      acc        <= '0;
      opnd       <= '0;
      hi_r       <= '0;
      lo_r       <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      div_zero_r <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      neg_a      <= 1'b0;
      neg_b      <= 1'b0;
      is_div     <= 1'b0;
`endif
    end else begin
      done_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start && (bus.alu_op == ALU_MULT)) begin
            acc        <= {{WIDTH{1'b0}}, b_in_c};
            opnd       <= a_in_c;
            cnt        <= '0;
            busy_r     <= 1'b1;
            div_zero_r <= 1'b0;
            state      <= ST_MUL;
`ifdef MULDIV_SIGNED_EN
            neg_a      <= bus.op_a[WIDTH-1];
            neg_b      <= bus.op_b[WIDTH-1];
            is_div     <= 1'b0;
`endif
          end else if (bus.start && (bus.alu_op == ALU_DIV)) begin
            busy_r <= 1'b1;
            if (bus.op_b != '0) begin
              acc        <= {{WIDTH{1'b0}}, a_in_c};
              opnd       <= b_in_c;
              cnt        <= '0;
              div_zero_r <= 1'b0;
              state      <= ST_DIV;
`ifdef MULDIV_SIGNED_EN
              neg_a      <= bus.op_a[WIDTH-1];
              neg_b      <= bus.op_b[WIDTH-1];
              is_div     <= 1'b1;
`endif
            end else begin
              hi_r       <= bus.op_a;
              lo_r       <= '1;
              div_zero_r <= 1'b1;
              done_r     <= 1'b1;
              state      <= ST_DONE;
            end
          end
        end
        ST_MUL, ST_DIV: begin
          acc <= step_nxt_c;
          cnt <= cnt + 1'b1;
          if (last_c) begin
`ifdef MULDIV_SIGNED_EN
            state  <= ST_FIX;
`else
            hi_r   <= step_nxt_c[2*WIDTH-1:WIDTH];
            lo_r   <= step_nxt_c[WIDTH-1:0];
            done_r <= 1'b1;
            state  <= ST_DONE;
`endif
          end
        end
`ifdef MULDIV_SIGNED_EN
        ST_FIX: begin
          if (is_div) begin
            hi_r <= rem_fix_c;
            lo_r <= quo_fix_c;
          end else begin
            hi_r <= prod_fix_c[2*WIDTH-1:WIDTH];
            lo_r <= prod_fix_c[WIDTH-1:0];
          end
          done_r <= 1'b1;
          state  <= ST_DONE;
        end
`endif
        ST_DONE: begin
          busy_r <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          busy_r <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.hi       = hi_r;
  assign bus.lo       = lo_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.div_zero = div_zero_r;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed corner cases plus random
// MULT/DIV traffic compared against an arithmetic reference model.
module tb_muldiv_seq;
  import muldiv_seq_pkg::*;

  localparam int unsigned WIDTH = 32;
`ifdef MULDIV_SIGNED_EN
  localparam int LAT = WIDTH + 2;
`else
  localparam int LAT = WIDTH + 1;
`endif
  localparam int MAX_CYC = 200;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  muldiv_seq_if #(.WIDTH(WIDTH)) bus ();

  muldiv_seq #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_hi   = '0;
  logic [31:0] exp_lo   = '0;
  logic        exp_dz   = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the operands as the build interprets them.
  task automatic ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] h, output logic [31:0] l, output int lat);
    logic [63:0] p;
`ifdef MULDIV_SIGNED_EN
    longint sa, sb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
`endif
    lat = LAT;
    if (op == ALU_MULT) begin
`ifdef MULDIV_SIGNED_EN
      p = 64'(sa * sb);
`else
      p = {32'd0, a} * {32'd0, b};
`endif
      h = p[63:32];
      l = p[31:0];
    end else if (b == 32'd0) begin
      h   = a;
      l   = 32'hFFFF_FFFF;
      lat = 1;
    end else begin
`ifdef MULDIV_SIGNED_EN
      q = sa / sb;
      r = sa % sb;
      h = 32'(r);
      l = 32'(q);
`else
      h = a % b;
      l = a / b;
`endif
    end
  endtask

  // Issue one operation and follow it to completion. inject>0 drives a stray
  // start at that cycle; start_in_done drives a start while done is high.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int inject, input bit start_in_done);
    logic [31:0] h, l;
    int          lat, cyc;
    bit          busy_ok;
    ref_op(op, a, b, h, l, lat);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.alu_op = op;
    bus.op_a   = a;
    bus.op_b   = b;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.op_a   = $urandom;
    bus.op_b   = $urandom;
    cyc     = 1;
    busy_ok = 1'b1;
    while (!bus.done && cyc < MAX_CYC) begin
      if (!bus.busy) busy_ok = 1'b0;
      if (bus.hi !== exp_hi || bus.lo !== exp_lo) busy_ok = 1'b0;
      if (cyc == inject) begin
        bus.start  = 1'b1;
        bus.alu_op = ALU_DIV;
        bus.op_a   = 32'd9;
        bus.op_b   = 32'd0;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    exp_hi = h;
    exp_lo = l;
    if (op == ALU_DIV && b == 32'd0) exp_dz = 1'b1;
    else exp_dz = 1'b0;
    check_eq({tag, "_latency"}, 64'(cyc), 64'(lat));
    check_eq({tag, "_busy_hold"}, 64'(busy_ok), 64'd1);
    check_eq({tag, "_busy_at_done"}, 64'(bus.busy), 64'd1);
    check_eq({tag, "_hi"}, 64'(bus.hi), 64'(h));
    check_eq({tag, "_lo"}, 64'(bus.lo), 64'(l));
    check_eq({tag, "_div_zero"}, 64'(bus.div_zero), 64'(exp_dz));
    if (start_in_done) begin
      bus.start  = 1'b1;
      bus.alu_op = ALU_MULT;
      bus.op_a   = 32'd2;
      bus.op_b   = 32'd2;
    end
    @(negedge clk);
    bus.start = 1'b0;
    check_eq({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
    check_eq({tag, "_busy_after"}, 64'(bus.busy), 64'd0);
    check_eq({tag, "_hi_held"}, 64'(bus.hi), 64'(exp_hi));
    check_eq({tag, "_lo_held"}, 64'(bus.lo), 64'(exp_lo));
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;

    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.alu_op = ALU_NOP;
    bus.op_a   = '0;
    bus.op_b   = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_hi", 64'(bus.hi), 64'd0);
    check_eq("rst_lo", 64'(bus.lo), 64'd0);
    check_eq("rst_busy", 64'(bus.busy), 64'd0);
    check_eq("rst_done", 64'(bus.done), 64'd0);
    check_eq("rst_div_zero", 64'(bus.div_zero), 64'd0);
    reset = 1'b0;

    run_op("mul_7x6", ALU_MULT, 32'd7, 32'd6, 0, 1'b0);
    run_op("div_100_7", ALU_DIV, 32'd100, 32'd7, 0, 1'b0);
    run_op("div_m100_7", ALU_DIV, 32'hFFFF_FF9C, 32'd7, 0, 1'b0);
    run_op("div_5_0", ALU_DIV, 32'd5, 32'd0, 0, 1'b0);
    run_op("mul_clr_dz", ALU_MULT, 32'd3, 32'd5, 0, 1'b0);
    run_op("mul_max", ALU_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
    run_op("mul_inject", ALU_MULT, 32'd1234, 32'd5678, 10, 1'b0);
    repeat (LAT + 2) begin
      @(negedge clk);
      check_eq("no_extra_done", 64'(bus.done), 64'd0);
    end
    run_op("div_start_in_done", ALU_DIV, 32'd1000, 32'd33, 0, 1'b1);

    // Non-MULT/DIV op codes are ignored.
    @(negedge clk);
    bus.start  = 1'b1;
    bus.alu_op = ALU_ADD;
    bus.op_a   = 32'd1;
    bus.op_b   = 32'd0;
    @(negedge clk);
    bus.start = 1'b0;
    check_eq("ign_op_busy", 64'(bus.busy), 64'd0);
    check_eq("ign_op_lo", 64'(bus.lo), 64'(exp_lo));

    // Reset in the middle of a divide aborts it immediately.
    @(negedge clk);
    bus.start  = 1'b1;
    bus.alu_op = ALU_DIV;
    bus.op_a   = 32'd1000;
    bus.op_b   = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (14) @(negedge clk);
    check_eq("pre_rst_busy", 64'(bus.busy), 64'd1);
    reset = 1'b1;
    #1;
    check_eq("abort_busy", 64'(bus.busy), 64'd0);
    check_eq("abort_hi", 64'(bus.hi), 64'd0);
    check_eq("abort_lo", 64'(bus.lo), 64'd0);
    @(negedge clk);
    reset  = 1'b0;
    exp_hi = '0;
    exp_lo = '0;
    exp_dz = 1'b0;
    run_op("mul_3x3", ALU_MULT, 32'd3, 32'd3, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      op = ($urandom_range(0, 1) == 0) ? ALU_MULT : ALU_DIV;
      a  = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1, 2:    b = 32'($urandom_range(1, 255));
        3:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      run_op("rand", op, a, b, 0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
